// File: rtl/lcd_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for the LCD panel bus: frames one byte with CS,
// shifts it out MSB first with a programmable SCK half-period, then pulses tx_done.
module lcd_spi_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       dc
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_H,
    SCK_L,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  // Only the bits still to be sent after bit7; bit7 goes straight to mosi.
  logic [6:0]       shift_q, shift_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             phase_end_c;

  assign phase_end_c = (div_q == DIV_LAST);

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d = state_q;
    div_d   = phase_end_c ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dc_d    = dc_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (tx_start) begin
          shift_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          dc_d    = tx_dc;
          bit_d   = 3'd7;
          cs_d    = 1'b0;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phase_end_c) begin
          sck_d   = 1'b1;
          state_d = SCK_H;
        end
      end
      SCK_H: begin
        if (phase_end_c) begin
          sck_d = 1'b0;
          if (bit_q == 3'd0) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
            state_d = SCK_L;
          end
        end
      end
      SCK_L: begin
        if (phase_end_c) begin
          sck_d   = 1'b1;
          state_d = SCK_H;
        end
      end
      HOLD: begin
        if (phase_end_c) begin
          cs_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        div_d   = '0;
        sck_d   = 1'b0;
        cs_d    = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 7'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs       = cs_q;
  assign dc       = dc_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Scoreboard bench for lcd_spi_tx: channel 0 runs CLK_DIV=2, channel 1 runs CLK_DIV=1;
// a bus monitor decodes each framed byte and checks it against queued expectations.
module tb_lcd_spi_tx;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       b2b;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tx_start [2];
  logic [7:0] tx_data  [2];
  logic       tx_dc    [2];
  logic       tx_ready [2];
  logic       tx_done  [2];
  logic       sck      [2];
  logic       mosi     [2];
  logic       cs       [2];
  logic       dc       [2];

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  lcd_spi_tx #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
    .tx_dc(tx_dc[0]), .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .sck(sck[0]),
    .mosi(mosi[0]), .cs(cs[0]), .dc(dc[0])
  );

  lcd_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
    .tx_dc(tx_dc[1]), .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .sck(sck[1]),
    .mosi(mosi[1]), .cs(cs[1]), .dc(dc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int ch);
    return (ch == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         ncyc = 0;
  int         rises    [2];
  int         cs_low   [2];
  int         cs_high  [2];
  int         acc      [2];
  int         last_rise[2];
  logic [7:0] sh       [2];
  logic       prev_sck [2];
  logic       prev_cs  [2];
  logic       bad_sck  [2];
  logic       bad_dc   [2];
  logic       bad_gap  [2];
  logic       fall_dc  [2];

  task automatic mon_clear(input int ch);
    rises[ch] = 0; cs_low[ch] = 0; cs_high[ch] = 0; acc[ch] = 0; last_rise[ch] = 0;
    sh[ch] = 8'h00; prev_sck[ch] = 1'b0; prev_cs[ch] = 1'b1;
    bad_sck[ch] = 1'b0; bad_dc[ch] = 1'b0; bad_gap[ch] = 1'b0; fall_dc[ch] = 1'b0;
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  initial begin
    mon_clear(0);
    mon_clear(1);
  end

  always begin
    @(negedge clk);
    #1;
    ncyc++;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        mon_clear(ch);
      end else begin
        if (sck[ch] && cs[ch]) bad_sck[ch] = 1'b1;
        if (!cs[ch]) begin
          if (prev_cs[ch]) begin
            if (qsize(ch) == 0) begin
              check($sformatf("ch%0d_cs_fall_unexpected", ch), 1, 0);
            end else begin
              exp_t e;
              e = qfront(ch);
              if (e.b2b) check($sformatf("ch%0d_b2b_cs_high", ch), cs_high[ch], 1);
              check($sformatf("ch%0d_dc_at_cs_fall", ch), int'(dc[ch]), int'(e.dc));
            end
            fall_dc[ch] = dc[ch];
            cs_low[ch] = 0; rises[ch] = 0; sh[ch] = 8'h00;
            bad_dc[ch] = 1'b0; bad_gap[ch] = 1'b0;
          end
          cs_low[ch]++;
          if (dc[ch] != fall_dc[ch]) bad_dc[ch] = 1'b1;
          if (sck[ch] && !prev_sck[ch]) begin
            if (rises[ch] > 0 && (ncyc - last_rise[ch]) != 2 * div_of(ch)) bad_gap[ch] = 1'b1;
            sh[ch] = {sh[ch][6:0], mosi[ch]};
            rises[ch]++;
            last_rise[ch] = ncyc;
          end
        end else begin
          cs_high[ch]++;
        end
        if (prev_cs[ch] && !cs[ch]) cs_high[ch] = 0;
        if (tx_done[ch]) begin
          if (qsize(ch) == 0) begin
            check($sformatf("ch%0d_done_unexpected", ch), 1, 0);
          end else begin
            exp_t e;
            e = qfront(ch);
            if (ch == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            check($sformatf("ch%0d_byte", ch), int'(sh[ch]), int'(e.data));
            check($sformatf("ch%0d_dc", ch), int'(fall_dc[ch]), int'(e.dc));
            check($sformatf("ch%0d_sck_rises", ch), rises[ch], 8);
            check($sformatf("ch%0d_cs_low_cycles", ch), cs_low[ch], 17 * div_of(ch));
            check($sformatf("ch%0d_done_latency", ch), ncyc - acc[ch], 1 + 17 * div_of(ch));
            check($sformatf("ch%0d_done_cs_ready", ch), int'({cs[ch], tx_ready[ch]}), 3);
            check($sformatf("ch%0d_flags_sckcs_dc_gap", ch),
                  int'({bad_sck[ch], bad_dc[ch], bad_gap[ch]}), 0);
          end
        end
        if (tx_start[ch] && tx_ready[ch]) acc[ch] = ncyc;
        prev_sck[ch] = sck[ch];
        prev_cs[ch]  = cs[ch];
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic send(input int ch, input logic [7:0] d, input logic dcv, input logic b2b);
    exp_t e;
    e.data = d; e.dc = dcv; e.b2b = b2b;
    if (ch == 0) q0.push_back(e); else q1.push_back(e);
    tx_start[ch] = 1'b1; tx_data[ch] = d; tx_dc[ch] = dcv;
    @(posedge clk);
    #1;
    tx_start[ch] = 1'b0; tx_data[ch] = ~d; tx_dc[ch] = ~dcv;
  endtask

  // Returns at the negedge where tx_done is seen.
  task automatic wait_done(input int ch);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done[ch]) return;
    end
    check($sformatf("ch%0d_done_timeout", ch), 0, 1);
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      tx_start[ch] = 1'b0; tx_data[ch] = 8'h00; tx_dc[ch] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state_ch0", int'({tx_ready[0], tx_done[0], sck[0], mosi[0], cs[0], dc[0]}), 6'b100010);
    check("reset_state_ch1", int'({tx_ready[1], tx_done[1], sck[1], mosi[1], cs[1], dc[1]}), 6'b100010);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 as data
    send(0, 8'hA5, 1'b1, 1'b0);
    wait_done(0);
    @(negedge clk);
    check("done_single_pulse", int'(tx_done[0]), 0);
    check("dc_holds_after", int'(dc[0]), 1);
    check("mosi_holds_last_bit", int'(mosi[0]), 1);

    // 0x2C command then 0xFF data back-to-back
    send(0, 8'h2C, 1'b0, 1'b0);
    wait_done(0);
    send(0, 8'hFF, 1'b1, 1'b1);
    wait_done(0);

    // mid-transfer request ignored
    @(negedge clk);
    send(0, 8'hA5, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    tx_start[0] = 1'b1; tx_data[0] = 8'h00; tx_dc[0] = 1'b0;
    @(negedge clk);
    tx_start[0] = 1'b0;
    wait_done(0);
    repeat (60) begin
      @(negedge clk);
      if (tx_done[0] || !cs[0]) check("ignored_start_no_second_xfer", 1, 0);
    end

    // asynchronous reset mid-transfer
    send(0, 8'hC3, 1'b1, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({tx_ready[0], tx_done[0], sck[0], mosi[0], cs[0], dc[0]}), 6'b100010);
    void'(q0.pop_back());
    repeat (2) @(negedge clk);
    check("reset_no_done", int'(tx_done[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b0);
    wait_done(0);

    // CLK_DIV=1 channel
    @(negedge clk);
    send(1, 8'h80, 1'b1, 1'b0);
    wait_done(1);
    @(negedge clk);
    send(1, 8'h01, 1'b0, 1'b0);
    wait_done(1);

    // idle stability
    begin
      int bad;
      bad = 0;
      repeat (100) begin
        @(negedge clk);
        if (sck[0] || !cs[0] || !tx_ready[0] || tx_done[0]) bad++;
        if (sck[1] || !cs[1] || !tx_ready[1] || tx_done[1]) bad++;
      end
      check("idle_stable_bad_cycles", bad, 0);
    end
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
